// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_divider_magnitude.sv
// Operand magnitude/sign split. Two's-complement when i_signed_mode=1, pass-through otherwise.
// Latency: combinational.
// Backpressure: none.
// Ports: i_val operand, i_signed_mode interpret as signed, o_mag unsigned magnitude, o_neg operand sign.
module div_magnitude #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_signed_mode,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_neg
);

  assign o_neg = i_signed_mode & i_val[WIDTH-1];
  // The most-negative value negates to itself, which read as unsigned is the
  // correct magnitude 2^(WIDTH-1).
  assign o_mag = o_neg ? -i_val : i_val;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per clock.
// Latency: done WIDTH+2 cycles after the accepting edge; 1 cycle for a zero divisor.
// Backpressure: start is only accepted in IDLE; requests while busy or in DONE are dropped.
// Ports: clk/reset (sync, active-high); start, signed_mode, dividend, divisor sampled together;
//        busy during CALC/FIX, done single-cycle pulse, div_zero sticky until next good start,
//        hi = remainder, lo = quotient (both held between operations).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t         r_state;
  div_state_t         w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_rem;      // upper half: partial remainder, lower half: dividend -> quotient
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic               w_zero;
  logic [WIDTH:0]     w_partial;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_q_fixed;
  logic [WIDTH-1:0]   w_r_fixed;

  div_magnitude #(.WIDTH(WIDTH)) u_dvd_mag (
    .i_val         (dividend),
    .i_signed_mode (signed_mode),
    .o_mag         (w_dvd_mag),
    .o_neg         (w_dvd_neg)
  );

  div_magnitude #(.WIDTH(WIDTH)) u_dvs_mag (
    .i_val         (divisor),
    .i_signed_mode (signed_mode),
    .o_mag         (w_dvs_mag),
    .o_neg         (w_dvs_neg)
  );

  assign w_zero = (divisor == '0);

  // Shifted partial remainder needs WIDTH+1 bits. Since the remainder is always
  // below the divisor, a non-borrowing result fits in WIDTH bits, so bit WIDTH
  // of the difference is a clean borrow flag.
  assign w_partial  = r_rem[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_partial - {1'b0, r_dvsr};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];

  assign w_q_fixed  = r_q_neg ? -r_rem[WIDTH-1:0]       : r_rem[WIDTH-1:0];
  assign w_r_fixed  = r_r_neg ? -r_rem[2*WIDTH-1:WIDTH] : r_rem[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = w_zero ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == LAST_ITER) begin
          w_next_state = FIX;
        end
      end
      FIX: begin
        busy         = 1'b1;
        w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvsr     <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_div_zero <= w_zero;
            if (!w_zero) begin
              r_rem   <= {{WIDTH{1'b0}}, w_dvd_mag};
              r_dvsr  <= w_dvs_mag;
              r_q_neg <= w_dvd_neg ^ w_dvs_neg;
              r_r_neg <= w_dvd_neg;
              r_cnt   <= '0;
            end
          end
        end
        CALC: begin
          r_rem <= {w_rem_next, r_rem[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          // Results land on the edge into DONE so they are valid alongside done.
          r_lo <= w_q_fixed;
          r_hi <= w_r_fixed;
        end
        default: ;
      endcase
    end
  end

  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
